demux_1ton_stream: RTL and testbench
====================================

Name: demux_1toN_stream

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshakes on the input and on every output channel.
- Generalises the 1-to-2 4-bit demux:
  - configurable data width and channel count;
  - one-entry holding register per channel;
  - backpressure;
  - a broadcast mode;
  - error counting for out-of-range selects.
- Sits between a single producer and N consumers in the datapath, e.g. routing operand words to several execution lanes.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- N, 2, number of output channels (2..16).
- SEL_W, $clog2(N), width of the select input (derived; do not override).
- CNT_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- X  in  WIDTH  input data word.
- X_VALID  in  1  input word valid.
- X_READY  out  1  block accepts the word this cycle.
- S  in  SEL_W  destination channel select; sampled with X.
- BCAST  in  1  when 1, the word goes to all N channels; S is ignored. Sampled with X.
- Y  out  N*WIDTH  output data; channel k occupies Y[k*WIDTH +: WIDTH].
- Y_VALID  out  N  per-channel output valid.
- Y_READY  in  N  per-channel consumer ready.
- ERR_CNT  out  CNT_W  count of dropped out-of-range transfers; saturating.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: Y_VALID=0, every Y lane=0, ERR_CNT=0. X_READY is combinational; it is 0 while RST_N=0.
- Reset mid-operation discards all held words; no output handshake completes during reset.
- Transfers:
  - Input transfer occurs when X_VALID & X_READY on a rising CLK edge.
  - Output transfer on channel k occurs when Y_VALID[k] & Y_READY[k].
- Per-channel slot state is EMPTY or FULL.
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain with no same-cycle load.
  - FULL -> FULL on drain plus load (pass-through, no bubble).
- Slot free(k) = !Y_VALID[k] | Y_READY[k].
- Unicast (BCAST=0, S<N):
  - X_READY = free(S).
  - On transfer, lane S loads X and Y_VALID[S]=1 next cycle.
  - Other channels are unaffected.
  - Latency: 1 cycle from input transfer to Y_VALID.
- Broadcast (BCAST=1):
  - X_READY = AND of free(k) over all k.
  - On transfer, all lanes load X and all Y_VALID=1 next cycle.
  - A broadcast is all-or-nothing; partial delivery is never allowed.
- Out-of-range select (BCAST=0, S>=N; only possible when N is not a power of 2):
  - X_READY=1 and the word is dropped.
  - ERR_CNT increments by 1, saturating at 2^CNT_W-1.
  - No lane changes.
- Output stability: while Y_VALID[k]=1 and Y_READY[k]=0, Y lane k is held stable.
- Lane clearing: when a lane drains without reload, it clears to 0 (idle lanes read as zero, as in the 1-to-2 demux).
- Y_READY[k] may be asserted while Y_VALID[k]=0; it has no effect.
- No combinational path from X to Y. X_READY depends combinationally on Y_READY, S and BCAST only.
- X_VALID deasserting without a transfer is legal; no state changes.

Decomposition:
- Shared package demux_pkg holds:
  - localparam defaults DEMUX_WIDTH_DEF=4, DEMUX_N_DEF=2, DEMUX_CNT_W_DEF=8;
  - function clog2_min1 (returns >=1 so SEL_W is never 0).
- Sub-module demux_chan_slot: one-entry valid/ready holding register.
  - Ports CLK, RST_N, LOAD, D[WIDTH], Q[WIDTH], VALID, READY, FREE.
  - Instantiated N times in a generate loop.
- The top level holds the select decode, broadcast AND-reduction, error counter and X_READY logic.

Test Plan:
- Reset: assert RST_N=0 mid-stream with slots full -> next cycle Y_VALID=0, Y=0, ERR_CNT=0, X_READY=0. After release, X_READY=1.
- Unicast, N=4, WIDTH=8, all Y_READY=1, X=8'hA5, S=2 -> one cycle later:
  - Y_VALID=4'b0100;
  - lane2=8'hA5, other lanes=0;
  - following cycle lane2 cleared if there is no new load.
- Backpressure, N=2, WIDTH=4: load X=4'h9 to S=1 with Y_READY=2'b00, then offer X=4'h3, S=1 -> X_READY=0; lane1 holds 4'h9. Raise Y_READY[1] -> same-cycle accept; next cycle lane1=4'h3, Y_VALID[1]=1.
- Broadcast, N=4, X=8'h5C, Y_READY=4'b1011 with lane2 full -> X_READY=0. Set Y_READY=4'b1111 -> accepted; next cycle all lanes=8'h5C, Y_VALID=4'b1111.
- Out-of-range, N=3, S=3, X_VALID=1 for 300 cycles -> X_READY=1 throughout; no Y_VALID; ERR_CNT saturates at 255.
- Throughput, N=2: back-to-back alternating S=0/1 with all Y_READY=1 -> one transfer per cycle, data order preserved per lane, no bubbles.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;
  localparam int DEMUX_WIDTH_DEF = 4;
  localparam int DEMUX_N_DEF     = 2;
  localparam int DEMUX_CNT_W_DEF = 8;

  // Select width for n channels; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/demux_chan_slot.sv
// One-entry valid/ready holding register for a single output channel.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  input  logic             READY,
  output logic             FREE
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A load always wins over a drain, giving bubble-free pass-through.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (LOAD) begin
      r_data  <= D;
      r_valid <= 1'b1;
    end else if (r_valid && READY) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end
  end

  assign Q     = r_data;
  assign VALID = r_valid;
  assign FREE  = !r_valid || READY;

endmodule

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer with unicast, broadcast and
// saturating counting of dropped out-of-range selects.
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int N     = DEMUX_N_DEF,
  parameter int SEL_W = clog2_min1(N),
  parameter int CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   X,
  input  logic               X_VALID,
  output logic               X_READY,
  input  logic [SEL_W-1:0]   S,
  input  logic               BCAST,
  output logic [N*WIDTH-1:0] Y,
  output logic [N-1:0]       Y_VALID,
  input  logic [N-1:0]       Y_READY,
  output logic [CNT_W-1:0]   ERR_CNT
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_free;
  logic [N-1:0]     w_load;
  logic             w_in_range;
  logic             w_sel_free;
  logic             w_xfer;
  logic             w_drop;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_in_range = ({1'b0, S} < N_EXT);
  assign w_sel_free = |(w_onehot & w_free);

  // Out-of-range selects are always accepted so the producer never stalls on them.
  always_comb begin
    X_READY = 1'b0;
    if (RST_N) begin
      if (BCAST)
        X_READY = &w_free;
      else if (w_in_range)
        X_READY = w_sel_free;
      else
        X_READY = 1'b1;
    end
  end

  assign w_xfer = X_VALID && X_READY;
  assign w_drop = w_xfer && !BCAST && !w_in_range;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign w_onehot[gi] = (S == SEL_W'(gi));
    assign w_load[gi]   = w_xfer && (BCAST || w_onehot[gi]);

    demux_chan_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .CLK   (CLK),
      .RST_N (RST_N),
      .LOAD  (w_load[gi]),
      .D     (X),
      .Q     (Y[gi*WIDTH +: WIDTH]),
      .VALID (Y_VALID[gi]),
      .READY (Y_READY[gi]),
      .FREE  (w_free[gi])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_err_cnt <= '0;
    else if (w_drop && (r_err_cnt != {CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Scoreboard bench for demux_1ton_stream (N=3, WIDTH=8): per-lane expected
// queues filled by the stimulus, drained and compared by a negedge monitor.
module tb_demux_1ton_stream;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  x = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [SW-1:0] s = '0;
  logic          bcast = 1'b0;
  logic [N*W-1:0] y;
  logic [N-1:0]  y_valid;
  logic [N-1:0]  y_ready = '0;
  logic [CW-1:0] err_cnt;

  logic [W-1:0]  q [N][$];
  int            exp_err = 0;
  logic          exp_ready = 1'b0;
  int            total = 0;
  int            bad = 0;
  logic          thr_on = 1'b0;
  int            thr_acc = 0;

  always #5 clk = ~clk;

  demux_1ton_stream #(.WIDTH(W), .N(N), .CNT_W(CW)) dut (
    .CLK(clk), .RST_N(rst_n), .X(x), .X_VALID(x_valid), .X_READY(x_ready),
    .S(s), .BCAST(bcast), .Y(y), .Y_VALID(y_valid), .Y_READY(y_ready),
    .ERR_CNT(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare lanes, pop on output handshake, then predict X_READY.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_x_ready", 32'(x_ready), 32'd0);
      exp_ready <= 1'b0;
    end else begin
      logic all_empty;
      logic er;
      for (int k = 0; k < N; k++) begin
        logic ev;
        ev = (q[k].size() != 0);
        chk($sformatf("y_valid[%0d]", k), 32'(y_valid[k]), 32'(ev));
        chk($sformatf("y_lane[%0d]", k), 32'(y[k*W +: W]), ev ? 32'(q[k][0]) : 32'd0);
        if (ev && y_ready[k]) void'(q[k].pop_front());
      end
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
      all_empty = 1'b1;
      for (int k = 0; k < N; k++) if (q[k].size() != 0) all_empty = 1'b0;
      if (bcast)            er = all_empty;
      else if (int'(s) < N) er = (q[int'(s)].size() == 0);
      else                  er = 1'b1;
      chk("x_ready", 32'(x_ready), 32'(er));
      exp_ready <= er;
      if (thr_on && x_ready) thr_acc++;
    end
  end

  // One cycle of stimulus; the reference model is updated at the clock edge.
  task automatic drive(input logic xv, input logic [W-1:0] xd, input logic [SW-1:0] sd,
                       input logic bd, input logic [N-1:0] yr);
    x_valid = xv; x = xd; s = sd; bcast = bd; y_ready = yr;
    @(posedge clk);
    if (rst_n && x_valid && exp_ready) begin
      if (bcast)
        for (int k = 0; k < N; k++) q[k].push_back(x);
      else if (int'(s) < N)
        q[int'(s)].push_back(x);
      else if (exp_err < (1 << CW) - 1)
        exp_err++;
    end
    #1;
  endtask

  task automatic idle(input logic [N-1:0] yr);
    drive(1'b0, '0, '0, 1'b0, yr);
  endtask

  initial begin
    repeat (3) idle('1);
    rst_n = 1'b1;
    idle('1);

    // Unicast to lane 2, then lane clears with no reload
    drive(1'b1, 8'hA5, 2'd2, 1'b0, 3'b111);
    idle(3'b111);
    idle(3'b111);

    // Backpressure on lane 1 then same-cycle accept on ready
    drive(1'b1, 8'h09, 2'd1, 1'b0, 3'b000);
    drive(1'b1, 8'h03, 2'd1, 1'b0, 3'b000);
    drive(1'b1, 8'h03, 2'd1, 1'b0, 3'b000);
    drive(1'b1, 8'h03, 2'd1, 1'b0, 3'b010);
    idle(3'b000);
    idle(3'b111);
    idle(3'b111);

    // Broadcast blocked by full lane 2, then accepted
    drive(1'b1, 8'h11, 2'd2, 1'b0, 3'b011);
    drive(1'b1, 8'h5C, 2'd0, 1'b1, 3'b011);
    drive(1'b1, 8'h5C, 2'd0, 1'b1, 3'b011);
    drive(1'b1, 8'h5C, 2'd0, 1'b1, 3'b111);
    idle(3'b000);
    idle(3'b111);
    idle(3'b111);

    // Out-of-range select, counter saturates
    for (int i = 0; i < 300; i++) drive(1'b1, 8'(i), 2'd3, 1'b0, 3'b111);
    @(negedge clk);
    chk("err_sat", 32'(err_cnt), 32'd255);
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 3'($urandom));

    // Reset mid-operation with all slots full
    drive(1'b1, 8'hE7, 2'd0, 1'b1, 3'b000);
    drive(1'b1, 8'hE7, 2'd0, 1'b1, 3'b000);
    drive(1'b1, 8'hE7, 2'd0, 1'b1, 3'b000);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    exp_err = 0;
    idle(3'b111);
    idle(3'b111);
    rst_n = 1'b1;
    idle(3'b000);

    // Throughput: alternating lanes back-to-back
    thr_on = 1'b1;
    for (int i = 0; i < 50; i++) drive(1'b1, 8'(8'h40 + i), 2'(i % 2), 1'b0, 3'b111);
    thr_on = 1'b0;
    chk("throughput", 32'(thr_acc), 32'd50);
    idle(3'b111);
    idle(3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
